// File: rtl/data_memory_sized_access.sv
// Data memory for the MEM stage: byte/half/word stores with lane enables,
// sign/zero-extended loads, a fixed-latency access FSM with programmable
// wait states, and a sticky first-fault address register.
module data_memory_sized_access #(
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Ready_o,
  output logic        Busy_o,
  output logic        Fault_o,
  output logic [31:0] Fault_Addr_o
);

  localparam int unsigned IDX_W     = $clog2(MEMORY_DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * MEMORY_DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_next;
  logic [3:0]        count, count_next;

  logic [31:0]       mem [MEMORY_DEPTH];

  logic [31:0]       off;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              in_range, aligned, legal;
  logic              is_load, is_store, both, req, accept, fault_now;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;

  logic [31:0]       word_p0;
  logic [2:0]        funct3_p0;
  logic [1:0]        lane_p0;
  logic              load_p0, fault_p0;

  // Select and extend the addressed lane(s) of a little-endian word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  ln);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {ln, 3'b000};
    b  = signed'(sh[7:0]);
    h  = signed'(sh[15:0]);
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b010:  return word;
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return 32'b0;
    endcase
  endfunction

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] store_enables(input logic [2:0] f3,
                                               input logic [1:0] ln);
    case (f3)
      3'b000:  return 4'b0001 << ln;
      3'b001:  return 4'b0011 << ln;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Address decode, legality and fault classification of the current request.
  always_comb begin
    off       = Address_i - BASE_ADDR;
    idx       = off[IDX_W+1:2];
    lane      = off[1:0];
    in_range  = (Address_i >= BASE_ADDR) && (off < SPAN);
    case (Funct3_i[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase
    is_load   = Mem_Read_i & ~Mem_Write_i;
    is_store  = Mem_Write_i & ~Mem_Read_i;
    both      = Mem_Read_i & Mem_Write_i;
    req       = Mem_Read_i | Mem_Write_i;
    if (is_load)
      legal = Funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (is_store)
      legal = Funct3_i inside {3'b000, 3'b001, 3'b010};
    else
      legal = 1'b0;
    accept    = (state == IDLE) && req && !reset;
    fault_now = both || !in_range || !aligned || !legal;
    be        = store_enables(Funct3_i, lane);
    case (Funct3_i)
      3'b000:  wdata_rep = {4{Write_Data_i[7:0]}};
      3'b001:  wdata_rep = {2{Write_Data_i[15:0]}};
      default: wdata_rep = Write_Data_i;
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic plus Busy/Ready decode from the current state.
  always_comb begin
    state_next = state;
    count_next = count;
    Ready_o    = 1'b0;
    Busy_o     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = WAIT;
          count_next = WAIT_INIT;
        end
      end
      WAIT: begin
        Busy_o = 1'b1;
        if (count == 4'd0) state_next = DONE;
        else               count_next = count - 4'd1;
      end
      DONE: begin
        Busy_o     = 1'b1;
        Ready_o    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: capture the RAM word and access attributes at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_p0   <= mem[idx];
      funct3_p0 <= Funct3_i;
      lane_p0   <= lane;
      load_p0   <= is_load;
      fault_p0  <= fault_now;
    end
  end

  // Store path: lane-enabled write at the acceptance edge, suppressed on fault.
  always_ff @(posedge clk) begin
    if (accept && is_store && !fault_now) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Load result register, updated on the transition into DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      Read_Data_o <= 32'b0;
    end else if (state == WAIT && count == 4'd0 && load_p0) begin
      Read_Data_o <= fault_p0 ? 32'b0 : load_extend(word_p0, funct3_p0, lane_p0);
    end
  end

  // Sticky fault flag; the address is latched only for the first fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      Fault_o      <= 1'b0;
      Fault_Addr_o <= 32'b0;
    end else if (accept && fault_now && !Fault_o) begin
      Fault_o      <= 1'b1;
      Fault_Addr_o <= Address_i;
    end
  end

endmodule

// File: tb/tb_data_memory_sized_access.sv
// Scoreboard bench: two instances (0 and 3 wait states) driven by directed
// accesses; a monitor per instance checks every Ready_o pulse against a queue.
module tb_data_memory_sized_access;

  localparam logic [31:0] B = 32'h1001_0000;

  typedef struct {
    int unsigned cyc;
    bit          chk;
    logic [31:0] data;
    bit          fault;
    logic [31:0] faddr;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        d0_wr, d0_rd, d1_wr, d1_rd;
  logic [2:0]  d0_f3, d1_f3;
  logic [31:0] d0_addr, d0_wd, d1_addr, d1_wd;
  logic [31:0] d0_rdata, d1_rdata, d0_faddr, d1_faddr;
  logic        d0_ready, d0_busy, d0_fault, d1_ready, d1_busy, d1_fault;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        m0, m1;

  data_memory_sized_access #(.MEMORY_DEPTH(256), .BASE_ADDR(B), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .Mem_Write_i(d0_wr), .Mem_Read_i(d0_rd),
    .Funct3_i(d0_f3), .Address_i(d0_addr), .Write_Data_i(d0_wd),
    .Read_Data_o(d0_rdata), .Ready_o(d0_ready), .Busy_o(d0_busy),
    .Fault_o(d0_fault), .Fault_Addr_o(d0_faddr));

  data_memory_sized_access #(.MEMORY_DEPTH(256), .BASE_ADDR(B), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(rst1), .Mem_Write_i(d1_wr), .Mem_Read_i(d1_rd),
    .Funct3_i(d1_f3), .Address_i(d1_addr), .Write_Data_i(d1_wd),
    .Read_Data_o(d1_rdata), .Ready_o(d1_ready), .Busy_o(d1_busy),
    .Fault_o(d1_fault), .Fault_Addr_o(d1_faddr));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      d0_rd = rd; d0_wr = wr; d0_f3 = f3; d0_addr = a; d0_wd = wd;
    end else begin
      d1_rd = rd; d1_wr = wr; d1_f3 = f3; d1_addr = a; d1_wd = wd;
    end
  endtask

  // One access: request for one cycle, expected response queued, then wait out the latency.
  task automatic acc(input int sel, input string tag, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input bit chk, input logic [31:0] ed, input bit ef, input logic [31:0] efa);
    exp_t e;
    int   ws;
    ws = (sel == 0) ? 0 : 3;
    @(negedge clk);
    drive(sel, rd, wr, f3, a, wd);
    e.cyc = cyc + 2 + ws; e.chk = chk; e.data = ed; e.fault = ef; e.faddr = efa; e.tag = tag;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (1 + ws) @(negedge clk);
  endtask

  task automatic check_idle(input int sel, input string tag);
    if (sel == 0) begin
      check({tag, "_rdata"}, d0_rdata, 32'h0);
      check({tag, "_ready"}, 32'(d0_ready), 32'h0);
      check({tag, "_busy"},  32'(d0_busy), 32'h0);
      check({tag, "_fault"}, 32'(d0_fault), 32'h0);
      check({tag, "_faddr"}, d0_faddr, 32'h0);
    end else begin
      check({tag, "_rdata"}, d1_rdata, 32'h0);
      check({tag, "_ready"}, 32'(d1_ready), 32'h0);
      check({tag, "_busy"},  32'(d1_busy), 32'h0);
      check({tag, "_fault"}, 32'(d1_fault), 32'h0);
      check({tag, "_faddr"}, d1_faddr, 32'h0);
    end
  endtask

  // Monitor for instance 0.
  always @(negedge clk) begin
    if (d0_ready === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0_unexpected_ready: got Ready_o=1 expected no response (cycle %0d)", cyc);
      end else begin
        m0 = q0.pop_front();
        check({m0.tag, "_ready_cycle"}, cyc, m0.cyc);
        if (m0.chk) check({m0.tag, "_rdata"}, d0_rdata, m0.data);
        check({m0.tag, "_fault"}, 32'(d0_fault), 32'(m0.fault));
        check({m0.tag, "_faddr"}, d0_faddr, m0.faddr);
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge clk) begin
    if (d1_ready === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_ready: got Ready_o=1 expected no response (cycle %0d)", cyc);
      end else begin
        m1 = q1.pop_front();
        check({m1.tag, "_ready_cycle"}, cyc, m1.cyc);
        if (m1.chk) check({m1.tag, "_rdata"}, d1_rdata, m1.data);
        check({m1.tag, "_fault"}, 32'(d1_fault), 32'(m1.fault));
        check({m1.tag, "_faddr"}, d1_faddr, m1.faddr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    check_idle(0, "rst0");
    check_idle(1, "rst1");

    // Instance 0: sized stores and loads, no faults yet.
    acc(0, "sw_w0",    0, 1, 3'b010, B+32'h000, 32'hA5A5_A5A5, 0, 32'h0,         0, 32'h0);
    acc(0, "sw_w1",    0, 1, 3'b010, B+32'h004, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0);
    acc(0, "lw_w1",    1, 0, 3'b010, B+32'h004, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0);
    acc(0, "sb_5",     0, 1, 3'b000, B+32'h005, 32'h1234_5680, 0, 32'h0,         0, 32'h0);
    acc(0, "lb_5",     1, 0, 3'b000, B+32'h005, 32'h0,         1, 32'hFFFF_FF80, 0, 32'h0);
    acc(0, "lbu_5",    1, 0, 3'b100, B+32'h005, 32'h0,         1, 32'h0000_0080, 0, 32'h0);
    acc(0, "lw_sb",    1, 0, 3'b010, B+32'h004, 32'h0,         1, 32'hDEAD_80EF, 0, 32'h0);
    acc(0, "sh_6",     0, 1, 3'b001, B+32'h006, 32'hABCD_8001, 0, 32'h0,         0, 32'h0);
    acc(0, "lh_6",     1, 0, 3'b001, B+32'h006, 32'h0,         1, 32'hFFFF_8001, 0, 32'h0);
    acc(0, "lhu_6",    1, 0, 3'b101, B+32'h006, 32'h0,         1, 32'h0000_8001, 0, 32'h0);
    acc(0, "lw_sh",    1, 0, 3'b010, B+32'h004, 32'h0,         1, 32'h8001_80EF, 0, 32'h0);
    acc(0, "lb_7",     1, 0, 3'b000, B+32'h007, 32'h0,         1, 32'hFFFF_FF80, 0, 32'h0);
    acc(0, "lbu_4",    1, 0, 3'b100, B+32'h004, 32'h0,         1, 32'h0000_00EF, 0, 32'h0);
    acc(0, "lh_4",     1, 0, 3'b001, B+32'h004, 32'h0,         1, 32'hFFFF_80EF, 0, 32'h0);
    acc(0, "sw_last",  0, 1, 3'b010, B+32'h3FC, 32'h1234_5678, 0, 32'h0,         0, 32'h0);
    acc(0, "lw_last",  1, 0, 3'b010, B+32'h3FC, 32'h0,         1, 32'h1234_5678, 0, 32'h0);
    acc(0, "lhu_3fe",  1, 0, 3'b101, B+32'h3FE, 32'h0,         1, 32'h0000_1234, 0, 32'h0);
    acc(0, "lb_3fd",   1, 0, 3'b000, B+32'h3FD, 32'h0,         1, 32'h0000_0056, 0, 32'h0);
    acc(0, "sw_w2",    0, 1, 3'b010, B+32'h008, 32'h1122_3344, 0, 32'h0,         0, 32'h0);

    // Instance 0: faults; the first faulting address must stick.
    acc(0, "lw_mis",   1, 0, 3'b010, B+32'h002, 32'h0,         1, 32'h0,         1, B+32'h002);
    acc(0, "sw_oor",   0, 1, 3'b010, B+32'h400, 32'h5555_5555, 0, 32'h0,         1, B+32'h002);
    acc(0, "lw_w0",    1, 0, 3'b010, B+32'h000, 32'h0,         1, 32'hA5A5_A5A5, 1, B+32'h002);
    acc(0, "both",     1, 1, 3'b010, B+32'h008, 32'hFFFF_FFFF, 0, 32'h0,         1, B+32'h002);
    acc(0, "lw_w2a",   1, 0, 3'b010, B+32'h008, 32'h0,         1, 32'h1122_3344, 1, B+32'h002);
    acc(0, "st_f011",  0, 1, 3'b011, B+32'h008, 32'h0,         0, 32'h0,         1, B+32'h002);
    acc(0, "lw_w2b",   1, 0, 3'b010, B+32'h008, 32'h0,         1, 32'h1122_3344, 1, B+32'h002);
    acc(0, "sh_mis",   0, 1, 3'b001, B+32'h005, 32'h0,         0, 32'h0,         1, B+32'h002);
    acc(0, "lw_w1c",   1, 0, 3'b010, B+32'h004, 32'h0,         1, 32'h8001_80EF, 1, B+32'h002);
    acc(0, "lw_below", 1, 0, 3'b010, 32'h1000_FFFC, 32'h0,     1, 32'h0,         1, B+32'h002);
    acc(0, "lbu_w2",   1, 0, 3'b100, B+32'h008, 32'h0,         1, 32'h0000_0044, 1, B+32'h002);
    acc(0, "ld_f011",  1, 0, 3'b011, B+32'h008, 32'h0,         1, 32'h0,         1, B+32'h002);

    // Instance 1 (3 wait states): busy window, ignored request, reset abort.
    acc(1, "w_sw",     0, 1, 3'b010, B+32'h010, 32'hCAFE_F00D, 0, 32'h0,         0, 32'h0);
    @(negedge clk);                                              // cycle T
    drive(1, 1'b1, 1'b0, 3'b010, B+32'h010, 32'h0);
    e.cyc = cyc + 5; e.chk = 1; e.data = 32'hCAFE_F00D; e.fault = 0; e.faddr = 32'h0; e.tag = "w_lw";
    q1.push_back(e);
    @(negedge clk);                                              // T+1
    check("w_busy_t1", 32'(d1_busy), 32'h1);
    check("w_ready_t1", 32'(d1_ready), 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);                                              // T+2: ignored store
    check("w_busy_t2", 32'(d1_busy), 32'h1);
    drive(1, 1'b0, 1'b1, 3'b010, B+32'h010, 32'h0);
    @(negedge clk);                                              // T+3
    check("w_busy_t3", 32'(d1_busy), 32'h1);
    check("w_ready_t3", 32'(d1_ready), 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);                                              // T+4
    check("w_busy_t4", 32'(d1_busy), 32'h1);
    check("w_ready_t4", 32'(d1_ready), 32'h0);
    @(negedge clk);                                              // T+5
    check("w_busy_t5", 32'(d1_busy), 32'h1);
    check("w_ready_t5", 32'(d1_ready), 32'h1);
    @(negedge clk);                                              // T+6
    check("w_busy_t6", 32'(d1_busy), 32'h0);
    check("w_ready_t6", 32'(d1_ready), 32'h0);
    acc(1, "w_lw_again", 1, 0, 3'b010, B+32'h010, 32'h0,   1, 32'hCAFE_F00D, 0, 32'h0);
    acc(1, "w_lw_oor",   1, 0, 3'b010, 32'h2000_0000, 32'h0, 1, 32'h0,       1, 32'h2000_0000);
    acc(1, "w_lw_ok",    1, 0, 3'b010, B+32'h010, 32'h0,   1, 32'hCAFE_F00D, 1, 32'h2000_0000);

    @(negedge clk);                                              // T: access to be aborted
    drive(1, 1'b1, 1'b0, 3'b010, B+32'h010, 32'h0);
    @(negedge clk);                                              // T+1
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);                                              // T+2
    @(negedge clk);                                              // T+3
    rst1 = 1'b1;
    @(negedge clk);                                              // T+4
    rst1 = 1'b0;
    check_idle(1, "abort");
    repeat (4) @(negedge clk);
    check("abort_busy_late", 32'(d1_busy), 32'h0);
    acc(1, "w_lw_post", 1, 0, 3'b010, B+32'h010, 32'h0,    1, 32'hCAFE_F00D, 0, 32'h0);

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
